// File: rtl/pipe_stage_elastic.sv
// Elastic register pipeline with per-stage valid bits and bubble collapsing.
// The chained ready lets each stage accept whenever any slot at or beyond it
// is empty or the consumer is taking the head this cycle. en freezes all
// state. flush squashes every valid bit but keeps the payload registers.
module pipe_stage_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             in_fire;
  logic             out_fire;
  logic [CW-1:0]    count_nxt;

  // Ready chain, evaluated from the output end back toward stage 0.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--) begin
      rdy[i] = ~v[i] | rdy[i+1];
    end
  end

  // Handshakes qualified by en and flush; population tracked incrementally.
  always_comb begin
    in_ready  = en & ~flush & rdy[0];
    out_valid = v[DEPTH-1] & ~flush;
    out_fire  = out_valid & out_ready & en;
    in_fire   = in_valid & in_ready;
    out_data  = d[DEPTH-1];
    count_nxt = count + CW'(in_fire) - CW'(out_fire);
  end

  // Stage registers: a ready stage takes its predecessor (or the input),
  // so empty slots are overwritten and bubbles disappear under back-pressure.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v     <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else if (en) begin
      if (flush) begin
        v     <= '0;
        count <= '0;
      end else begin
        if (rdy[0]) begin
          v[0] <= in_fire;
          if (in_fire) begin
            d[0] <= in_data;
          end
        end
        for (int i = 1; i < DEPTH; i++) begin
          if (rdy[i]) begin
            v[i] <= v[i-1];
            d[i] <= d[i-1];
          end
        end
        count <= count_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic (WIDTH=32, DEPTH=3).
// The reference keeps an ordered list of in-flight payloads with their slot
// positions; the monitor compares every cycle against that list.
module tb_pipe_stage_elastic;
  localparam int W = 32;
  localparam int D = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          en = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic [1:0]    count;

  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } item_t;

  item_t        q[$];
  logic [W-1:0] fired[$];
  int           fired_cyc[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           peak = 0;
  int           base;
  bit           mon_on = 1'b0;

  pipe_stage_elastic #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: head leaves when at the last slot and consumer ready; every
  // other payload advances one slot unless blocked by the one ahead of it.
  task automatic model_step();
    bit ofire, ifire;
    int lim;
    if (RST) begin
      q.delete();
    end else if (en) begin
      if (flush) begin
        q.delete();
      end else begin
        ofire = (q.size() > 0) && (q[0].pos == D-1) && out_ready;
        ifire = in_valid && ((q.size() < D) || out_ready);
        if (ofire) void'(q.pop_front());
        lim = D-1;
        for (int k = 0; k < q.size(); k++) begin
          q[k].pos = (q[k].pos + 1 < lim) ? q[k].pos + 1 : lim;
          lim = q[k].pos - 1;
        end
        if (ifire) q.push_back('{data: in_data, pos: 0});
      end
    end
  endtask

  initial forever begin
    @(posedge CLK or posedge RST);
    model_step();
  end

  // Monitor: compare handshake, population and head payload each cycle.
  initial forever begin
    @(negedge CLK);
    #1;
    if (mon_on && !RST) begin
      bit ev;
      ev = !flush && (q.size() > 0) && (q[0].pos == D-1);
      chk("in_ready", 32'(in_ready), 32'(en && !flush && ((q.size() < D) || out_ready)));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("count", 32'(count), 32'(q.size()));
      if (ev) chk("out_data", out_data, q[0].data);
      if (int'(count) > peak) peak = int'(count);
      if (out_valid && out_ready && en) begin
        fired.push_back(out_data);
        fired_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive(input bit e, input bit f, input bit iv, input logic [W-1:0] id, input bit ordy);
    @(negedge CLK);
    en = e; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, '0, ordy);
  endtask

  task automatic clear_log();
    fired.delete();
    fired_cyc.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    mon_on = 1'b1;

    // Streaming: three words, outputs three cycles later back to back
    clear_log();
    peak = 0;
    drive(1, 0, 1, 32'hA0, 1);
    base = cyc;
    drive(1, 0, 1, 32'hA1, 1);
    drive(1, 0, 1, 32'hA2, 1);
    idle(5, 1);
    #2;
    chk("stream_n", 32'(fired.size()), 32'd3);
    for (int k = 0; k < 3 && k < fired.size(); k++) begin
      chk("stream_data", fired[k], 32'hA0 + 32'(k));
      chk("stream_cyc", 32'(fired_cyc[k]), 32'(base + 3 + k));
    end
    chk("stream_peak", 32'(peak), 32'd3);

    // Back-pressure: fourth word refused, then ordered drain
    clear_log();
    drive(1, 0, 1, 32'hB0, 0);
    drive(1, 0, 1, 32'hB1, 0);
    drive(1, 0, 1, 32'hB2, 0);
    drive(1, 0, 1, 32'hB3, 0);
    #2;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_count", 32'(count), 32'd3);
    idle(6, 1);
    #2;
    chk("bp_n", 32'(fired.size()), 32'd3);
    for (int k = 0; k < 3 && k < fired.size(); k++) chk("bp_data", fired[k], 32'hB0 + 32'(k));

    // Bubble collapse
    clear_log();
    drive(1, 0, 1, 32'h11, 0);
    idle(2, 0);
    drive(1, 0, 1, 32'h22, 0);
    idle(1, 0);
    #2;
    chk("bub_count", 32'(count), 32'd2);
    chk("bub_head", out_data, 32'h11);
    idle(4, 1);
    #2;
    chk("bub_n", 32'(fired.size()), 32'd2);
    if (fired.size() == 2) begin
      chk("bub_d0", fired[0], 32'h11);
      chk("bub_d1", fired[1], 32'h22);
      chk("bub_adjacent", 32'(fired_cyc[1] - fired_cyc[0]), 32'd1);
    end

    // Flush of a full pipe, then refill latency
    clear_log();
    drive(1, 0, 1, 32'hC0, 0);
    drive(1, 0, 1, 32'hC1, 0);
    drive(1, 0, 1, 32'hC2, 0);
    drive(1, 1, 1, 32'h55, 1);
    #2;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    idle(1, 0);
    #2;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_out_valid_next", 32'(out_valid), 32'd0);
    drive(1, 0, 1, 32'h66, 1);
    base = cyc;
    idle(5, 1);
    #2;
    chk("fl_n", 32'(fired.size()), 32'd1);
    if (fired.size() == 1) begin
      chk("fl_refill_data", fired[0], 32'h66);
      chk("fl_refill_cyc", 32'(fired_cyc[0]), 32'(base + 3));
    end

    // Freeze with a flush pulse while en=0
    clear_log();
    drive(1, 0, 1, 32'hE0, 1);
    base = cyc;
    drive(1, 0, 1, 32'hE1, 1);
    drive(1, 0, 1, 32'hE2, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, (i == 2), 1, 32'hDEAD0000 + 32'(i), 1);
      #2;
      chk("frz_count", 32'(count), 32'd3);
      chk("frz_in_ready", 32'(in_ready), 32'd0);
    end
    drive(1, 0, 1, 32'hE3, 1);
    drive(1, 0, 1, 32'hE4, 1);
    drive(1, 0, 1, 32'hE5, 1);
    idle(6, 1);
    #2;
    chk("frz_n", 32'(fired.size()), 32'd6);
    for (int k = 0; k < 6 && k < fired.size(); k++) begin
      chk("frz_data", fired[k], 32'hE0 + 32'(k));
      chk("frz_cyc", 32'(fired_cyc[k]), 32'(base + 8 + k));
    end

    // Asynchronous reset with two words in flight
    clear_log();
    drive(1, 0, 1, 32'hF0, 0);
    drive(1, 0, 1, 32'hF1, 0);
    idle(1, 0);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    #1;
    RST = 1'b0;
    idle(5, 1);
    #2;
    chk("arst_leftover", 32'(fired.size()), 32'd0);

    // Randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
            1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0);
    end
    idle(10, 1);
    #2;
    chk("final_count", 32'(count), 32'd0);
    chk("final_model_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32: payload bits per stage.
REQ-002 The module SHALL have parameter DEPTH, default 2: number of register stages, legal range 1..8.
REQ-003 Port CLK, input, 1: clock; all state updates on its rising edge.
REQ-004 Port RST, input, 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
REQ-005 Port en, input, 1: global advance gate, e.g. ihit; when 0, no stage moves and no handshake completes.
REQ-006 Port flush, input, 1: synchronous squash of all stages.
REQ-007 Port in_valid, input, 1: upstream payload valid.
REQ-008 Port in_data, input, WIDTH: upstream payload.
REQ-009 Port in_ready, output, 1: stage 0 can accept this cycle.
REQ-010 Port out_valid, output, 1: last stage holds valid payload.
REQ-011 Port out_data, output, WIDTH: last-stage payload, registered.
REQ-012 Port out_ready, input, 1: downstream accepts.
REQ-013 Port count, output, $clog2(DEPTH+1): number of valid stages, registered.

Function
REQ-014 Each stage i (0..DEPTH-1) SHALL hold v[i] and d[i]; stage DEPTH-1 drives out_valid/out_data directly.
REQ-015 rdy[DEPTH-1] SHALL equal ~v[DEPTH-1] | out_ready; rdy[i] SHALL equal ~v[i] | rdy[i+1] for i < DEPTH-1.
REQ-016 in_ready SHALL equal en & ~flush & rdy[0], combinationally.
REQ-017 out_valid SHALL equal v[DEPTH-1] & ~flush; out_fire = out_valid & out_ready & en.
REQ-018 in_fire SHALL equal in_valid & in_ready; on in_fire, stage 0 SHALL load in_data with v[0]=1.
REQ-019 With en=1 and no flush, stage i+1 SHALL load d[i] whenever rdy[i+1]=1; v[i+1] takes v[i], so bubbles propagate and are collapsed.
REQ-020 A stage with v=0 SHALL always be loadable, so bubbles are squeezed out under back-pressure.
REQ-021 A stage with rdy=0 SHALL hold d and v unchanged.
REQ-022 en=0 SHALL freeze all d, v and count regardless of in_valid, out_ready and flush; flush is ignored while en=0.
REQ-023 flush=1 with en=1 SHALL clear all v next edge, take no input and complete no output; d SHALL be retained.
REQ-024 Latency SHALL be exactly DEPTH cycles from in_fire to out_valid when unstalled; throughput one payload per cycle.
REQ-025 count SHALL be next-cycle population: count + in_fire - out_fire, or 0 after flush; it never exceeds DEPTH.
REQ-026 A payload SHALL never be duplicated or dropped except by flush; simultaneous in_fire and out_fire on a full pipe SHALL be legal.
REQ-027 DEPTH=1 SHALL reduce to one register with in_ready = en & ~flush & (~v[0] | out_ready).

Reset
REQ-028 RST=1 SHALL asynchronously clear all v, all d (out_data=0) and count=0, so out_valid=0; in_ready follows REQ-016.
REQ-029 RST asserted mid-transfer SHALL discard all in-flight payloads; the first rising edge after RST release SHALL behave as an empty pipe.

Verification (WIDTH=32, DEPTH=3)
REQ-030 Streaming: en=1, out_ready=1, in 0xA0,0xA1,0xA2 on cycles 0-2 -> out_valid with 0xA0,0xA1,0xA2 on cycles 3-5; count peaks at 3.
REQ-031 Back-pressure: out_ready=0, feed 4 words -> 3 accepted, in_ready=0 on the 4th, count=3; out_ready=1 -> words drain in order with no loss or duplication.
REQ-032 Bubble collapse: feed 0x11, idle 2 cycles, feed 0x22 with out_ready=0 -> both words adjacent in stages 2 and 1; count=2.
REQ-033 Flush: full pipe, flush=1 with in_valid=1 and out_ready=1 for one cycle -> next cycle out_valid=0, count=0, nothing consumed; refill gives first out_valid after 3 cycles.
REQ-034 Freeze: en=0 for 5 cycles mid-stream with flush pulsed -> d, v and count unchanged, in_ready=0, no out_fire; resume is identical to unstalled run.
REQ-035 Reset: RST pulse with 2 words in flight -> out_valid=0, out_data=0 and count=0 immediately, with no leftover words after release.
